// File: rtl/mac_accum_sequencer.sv
// rtl/mac_accum_sequencer.sv - control FSM and datapath for a LEN-pair multiply-accumulate
//
// Purpose: accepts LEN unsigned 16x16 operand pairs over a valid/ready handshake.
// Each product is registered, then added into a 32-bit accumulator through the
// shared Kogge-Stone adder. The final sum is presented over a valid/ready output
// handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                one-cycle pulse, honoured only in IDLE
//   in_valid/in_ready    operand pair handshake; in_ready is decoded from state
//   in_a, in_b           16-bit unsigned operands
//   out_valid/out_ready  result handshake
//   out_data             accumulated sum; reads zero outside DONE
//   out_ovf              sticky carry-out flag for the run; reads zero outside DONE
//   busy                 high whenever the FSM is not in IDLE
//
// Build option: define MAC_SATURATE_EN to clamp the accumulator at 0xFFFFFFFF
// on the first carry-out instead of wrapping. Handshake timing is identical in
// both builds.

module Kogge_stone_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  // Parallel-prefix carry network. Five doubling levels cover 32 bits.
  // The carry-in is folded into bit 0's generate, so g[i] becomes the carry out of bit i.
  always_comb begin
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] p0;
    p0 = a ^ b;
    g  = (a & b) | {31'b0, p0[0] & cin};
    p  = p0;
    for (int lvl = 0; lvl < 5; lvl++) begin
      g = g | (p & (g << (1 << lvl)));
      p = p & (p << (1 << lvl));
    end
    sum  = p0 ^ {g[30:0], cin};
    cout = g[31];
  end
endmodule

module mac_accum_sequencer #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADD, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t             state, state_nx;
  logic [31:0]        acc;
  logic [31:0]        prod_r;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic [31:0]        add_sum;
  logic               add_cout;

  Kogge_stone_32bit u_adder (
    .a    (acc),
    .b    (prod_r),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start)     state_nx = S_WAIT;
      S_WAIT: if (in_valid)  state_nx = S_ADD;
      S_ADD:  state_nx = (count == LAST) ? S_DONE : S_WAIT;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      prod_r <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
          end
        end
        S_WAIT: begin
          if (in_valid) prod_r <= 32'(in_a) * 32'(in_b);
        end
        S_ADD: begin
`ifdef MAC_SATURATE_EN
          // Once clamped, the accumulator stays at all-ones for the rest of the run.
          if (add_cout || acc == 32'hFFFF_FFFF) acc <= 32'hFFFF_FFFF;
          else                                  acc <= add_sum;
`else
          acc <= add_sum;
`endif
          ovf <= ovf | add_cout;
          if (count != LAST) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // All handshake outputs are pure state decodes, so in_valid never reaches in_ready combinationally.
  assign in_ready  = (state == S_WAIT);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_data  = (state == S_DONE) ? acc : 32'h0;
  assign out_ovf   = (state == S_DONE) ? ovf : 1'b0;
endmodule
